// File: rtl/neighbor_sink_scanner.sv
// Scans the neighbour table against the known-sink table in shared word memory and
// reports whether any foreign-cluster neighbour is a known sink (early-exit or full count).
module neighbor_sink_scanner #(
  parameter int                    WORD_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    RD_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] KSC_ADDR   = 16'h688,
  parameter logic [ADDR_WIDTH-1:0] NBC_ADDR   = 16'h68A,
  parameter logic [ADDR_WIDTH-1:0] SINK_BASE  = 16'h8,
  parameter logic [ADDR_WIDTH-1:0] NBR_BASE   = 16'h48,
  parameter logic [ADDR_WIDTH-1:0] CLU_BASE   = 16'hC8,
  parameter logic [ADDR_WIDTH-1:0] FLAG_ADDR  = 16'h2,
  parameter logic [ADDR_WIDTH-1:0] CNT_ADDR   = 16'h4,
  parameter int                    MAX_COUNT  = 64
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WORD_WIDTH-1:0] my_cluster_id,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  for_aggregation,
  output logic [WORD_WIDTH-1:0] match_count
);

  localparam int         IDX_W    = $clog2(MAX_COUNT + 1);
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY);

  typedef enum logic [3:0] {
    IDLE, RD_KSC, RD_NBC, RD_NBR, RD_CLU, RD_SINK, WR_FLAG, WR_CNT, DONE
  } state_t;

  function automatic logic [IDX_W-1:0] clamp_count(input logic [WORD_WIDTH-1:0] v);
    if (v > WORD_WIDTH'(MAX_COUNT)) return IDX_W'(MAX_COUNT);
    return IDX_W'(v);
  endfunction

  function automatic logic [WORD_WIDTH-1:0] sat_inc(input logic [WORD_WIDTH-1:0] v);
    return (&v) ? v : v + WORD_WIDTH'(1);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [IDX_W-1:0]      k);
    return base + (ADDR_WIDTH'(k) << 1);
  endfunction

  state_t                state, state_d;
  logic [1:0]            lat, lat_d;
  logic [IDX_W-1:0]      i, i_d, j, j_d;
  logic                  flag, flag_d;
  logic [WORD_WIDTH-1:0] cnt, cnt_d;

  logic                  mode_q;
  logic [WORD_WIDTH-1:0] cluster_q, nbr_id;
  logic [IDX_W-1:0]      ksc, nbc;

  logic                  launch, ld_ksc, ld_nbc, ld_nbr, capture, adv;
  logic [IDX_W-1:0]      i_inc, j_inc;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      lat   <= '0;
      i     <= '0;
      j     <= '0;
      flag  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      lat   <= lat_d;
      i     <= i_d;
      j     <= j_d;
      flag  <= flag_d;
      cnt   <= cnt_d;
    end
  end

  // Table counts, launch parameters and the current neighbour ID need no reset.
  always_ff @(posedge clock) begin
    if (launch) begin
      mode_q    <= mode;
      cluster_q <= my_cluster_id;
    end
    if (ld_ksc) ksc    <= clamp_count(mem_rdata);
    if (ld_nbc) nbc    <= clamp_count(mem_rdata);
    if (ld_nbr) nbr_id <= mem_rdata;
  end

  always_comb begin
    state_d   = state;
    lat_d     = lat;
    i_d       = i;
    j_d       = j;
    flag_d    = flag;
    cnt_d     = cnt;
    launch    = 1'b0;
    ld_ksc    = 1'b0;
    ld_nbc    = 1'b0;
    ld_nbr    = 1'b0;
    adv       = 1'b0;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    capture   = (lat == LAT_LAST);
    i_inc     = i + IDX_W'(1);
    j_inc     = j + IDX_W'(1);

    // Every read state strobes in its first cycle and captures RD_LATENCY cycles later.
    if (state inside {RD_KSC, RD_NBC, RD_NBR, RD_CLU, RD_SINK}) begin
      mem_rd_en = (lat == 2'd0);
      lat_d     = capture ? 2'd0 : lat + 2'd1;
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = RD_KSC;
          flag_d  = 1'b0;
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
          lat_d   = '0;
        end
      end
      RD_KSC: begin
        mem_addr = KSC_ADDR;
        if (capture) begin
          ld_ksc  = 1'b1;
          state_d = RD_NBC;
        end
      end
      RD_NBC: begin
        mem_addr = NBC_ADDR;
        if (capture) begin
          ld_nbc  = 1'b1;
          state_d = (ksc == '0 || clamp_count(mem_rdata) == '0) ? WR_FLAG : RD_NBR;
        end
      end
      RD_NBR: begin
        mem_addr = entry_addr(NBR_BASE, i);
        if (capture) begin
          ld_nbr  = 1'b1;
          state_d = RD_CLU;
        end
      end
      RD_CLU: begin
        mem_addr = entry_addr(CLU_BASE, i);
        if (capture) begin
          if (mem_rdata == cluster_q) begin
            adv = 1'b1;
          end else begin
            j_d     = '0;
            state_d = RD_SINK;
          end
        end
      end
      RD_SINK: begin
        mem_addr = entry_addr(SINK_BASE, j);
        if (capture) begin
          if (mem_rdata == nbr_id) begin
            cnt_d  = sat_inc(cnt);
            flag_d = 1'b1;
            if (mode_q) adv = 1'b1;
            else        state_d = WR_FLAG;
          end else if (j_inc == ksc) begin
            adv = 1'b1;
          end else begin
            j_d = j_inc;
          end
        end
      end
      WR_FLAG: begin
        mem_wr_en = 1'b1;
        mem_addr  = FLAG_ADDR;
        mem_wdata = WORD_WIDTH'(flag);
        state_d   = mode_q ? WR_CNT : DONE;
      end
      WR_CNT: begin
        mem_wr_en = 1'b1;
        mem_addr  = CNT_ADDR;
        mem_wdata = cnt;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      i_d     = i_inc;
      state_d = (i_inc == nbc) ? WR_FLAG : RD_NBR;
    end
  end

  assign busy            = (state != IDLE) && (state != DONE);
  assign done            = (state == DONE);
  assign for_aggregation = flag;
  assign match_count     = cnt;

endmodule

// File: tb/tb_neighbor_sink_scanner.sv
// Directed bench: two scanner instances (read latency 1 and 3) on a modelled shared word memory.
module tb_neighbor_sink_scanner;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        nrst;
  logic        mode;
  logic [15:0] cid;
  logic        start [2];
  logic        clr   [2];
  logic [15:0] addr  [2];
  logic        rd_en [2];
  logic        wr_en [2];
  logic [15:0] rdata [2];
  logic [15:0] wdata [2];
  logic        busy  [2];
  logic        done  [2];
  logic        fa    [2];
  logic [15:0] mc    [2];

  int checks = 0;
  int errors = 0;

  neighbor_sink_scanner #(.RD_LATENCY(1)) dut_l1 (
    .clock(clock), .nrst(nrst), .start(start[0]), .mode(mode), .my_cluster_id(cid),
    .mem_addr(addr[0]), .mem_rd_en(rd_en[0]), .mem_wr_en(wr_en[0]), .mem_rdata(rdata[0]),
    .mem_wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .for_aggregation(fa[0]),
    .match_count(mc[0]));

  neighbor_sink_scanner #(.RD_LATENCY(3)) dut_l3 (
    .clock(clock), .nrst(nrst), .start(start[1]), .mode(mode), .my_cluster_id(cid),
    .mem_addr(addr[1]), .mem_rd_en(rd_en[1]), .mem_wr_en(wr_en[1]), .mem_rdata(rdata[1]),
    .mem_wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .for_aggregation(fa[1]),
    .match_count(mc[1]));

  // Word memory with a read delay line; filler data is returned outside the valid slot.
  logic [15:0] mem [0:1023];
  logic [15:0] dl  [2][3];
  assign rdata[0] = dl[0][0];
  assign rdata[1] = dl[1][2];

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      dl[d][0] <= rd_en[d] ? mem[addr[d][10:1]] : 16'hBEEF;
      dl[d][1] <= dl[d][0];
      dl[d][2] <= dl[d][1];
    end
  end

  int          rd_cnt    [2];
  int          wr_cnt    [2];
  logic [15:0] max_nbr   [2];
  logic        pulse_err [2];
  logic        ovl_err   [2];
  logic        prev_rd   [2];
  logic [15:0] wa        [2][4];
  logic [15:0] wd        [2][4];

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      prev_rd[d] <= rd_en[d];
      if (clr[d]) begin
        rd_cnt[d]    <= 0;
        wr_cnt[d]    <= 0;
        max_nbr[d]   <= 16'h0;
        pulse_err[d] <= 1'b0;
        ovl_err[d]   <= 1'b0;
      end else begin
        if (rd_en[d]) begin
          rd_cnt[d] <= rd_cnt[d] + 1;
          if (addr[d] >= 16'h48 && addr[d] < 16'hC8 && addr[d] > max_nbr[d]) max_nbr[d] <= addr[d];
          if (prev_rd[d]) pulse_err[d] <= 1'b1;
          if (wr_en[d]) ovl_err[d] <= 1'b1;
        end
        if (wr_en[d]) begin
          if (wr_cnt[d] < 4) begin
            wa[d][wr_cnt[d]] <= addr[d];
            wd[d][wr_cnt[d]] <= wdata[d];
          end
          wr_cnt[d] <= wr_cnt[d] + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic load_common();
    mem[836] = 16'd2;   mem[837] = 16'd3;
    mem[4]   = 16'd5;   mem[5]   = 16'd9;
    mem[36]  = 16'd5;   mem[37]  = 16'd7;   mem[38]  = 16'd9;
    mem[100] = 16'd3;   mem[101] = 16'd4;   mem[102] = 16'd4;
  endtask

  task automatic launch(input int d, input logic m);
    @(negedge clock);
    mode     = m;
    start[d] = 1'b1;
    clr[d]   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start[d] = 1'b0;
    clr[d]   = 1'b0;
  endtask

  // Returns the number of clock edges from the accepting edge until done is seen high.
  task automatic wait_done(input int d, input logic m, input int bound, input int pulse_at,
                           output int lat);
    lat = 1;
    while (!done[d] && lat < bound) begin
      @(negedge clock);
      lat++;
      start[d] = (lat == pulse_at);
      mode     = (lat == pulse_at) ? ~m : m;
    end
    start[d] = 1'b0;
    mode     = m;
  endtask

  int lat;

  initial begin
    nrst = 1'b0; mode = 1'b0; cid = 16'd3;
    start[0] = 1'b0; start[1] = 1'b0;
    clr[0]   = 1'b1; clr[1]   = 1'b1;
    for (int k = 0; k < 1024; k++) mem[k] = 16'h0;
    #2;
    check("rst_busy",  32'(busy[0]),  0);
    check("rst_done",  32'(done[0]),  0);
    check("rst_addr",  32'(addr[0]),  0);
    check("rst_rd_en", 32'(rd_en[0]), 0);
    check("rst_wr_en", 32'(wr_en[0]), 0);
    check("rst_wdata", 32'(wdata[0]), 0);
    check("rst_flag",  32'(fa[0]),    0);
    check("rst_count", 32'(mc[0]),    0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    nrst = 1'b1;
    clr[0] = 1'b0; clr[1] = 1'b0;

    // Common setup, exhaustive mode
    load_common();
    launch(0, 1'b1);
    wait_done(0, 1'b1, 100, 0, lat);
    check("m1_done",    32'(done[0]), 1);
    check("m1_latency", lat, 27);
    check("m1_reads",   rd_cnt[0], 12);
    check("m1_writes",  wr_cnt[0], 2);
    check("m1_w0_addr", 32'(wa[0][0]), 32'h2);
    check("m1_w0_data", 32'(wd[0][0]), 1);
    check("m1_w1_addr", 32'(wa[0][1]), 32'h4);
    check("m1_w1_data", 32'(wd[0][1]), 1);
    check("m1_count",   32'(mc[0]), 1);
    check("m1_flag",    32'(fa[0]), 1);
    check("m1_busy",    32'(busy[0]), 0);
    check("m1_overlap", 32'(ovl_err[0]), 0);

    // Common setup, early-exit mode
    launch(0, 1'b0);
    wait_done(0, 1'b0, 100, 0, lat);
    check("m0_done",    32'(done[0]), 1);
    check("m0_latency", lat, 26);
    check("m0_reads",   rd_cnt[0], 12);
    check("m0_writes",  wr_cnt[0], 1);
    check("m0_w0_addr", 32'(wa[0][0]), 32'h2);
    check("m0_w0_data", 32'(wd[0][0]), 1);
    check("m0_flag",    32'(fa[0]), 1);

    // Read latency 3, both neighbours are sinks in a foreign cluster
    mem[837] = 16'd2;
    mem[36]  = 16'd5;  mem[37]  = 16'd9;
    mem[100] = 16'd4;  mem[101] = 16'd4;
    launch(1, 1'b1);
    wait_done(1, 1'b1, 200, 0, lat);
    check("l3_done",    32'(done[1]), 1);
    check("l3_latency", lat, 39);
    check("l3_reads",   rd_cnt[1], 9);
    check("l3_count",   32'(mc[1]), 2);
    check("l3_flag",    32'(fa[1]), 1);
    check("l3_pulse",   32'(pulse_err[1]), 0);
    check("l3_overlap", 32'(ovl_err[1]), 0);
    check("l3_w1_data", 32'(wd[1][1]), 2);
    check("l3_busy",    32'(busy[1]), 0);

    // No known sinks
    mem[836] = 16'd0;
    launch(0, 1'b0);
    wait_done(0, 1'b0, 100, 0, lat);
    check("ks0_done",    32'(done[0]), 1);
    check("ks0_latency", lat, 6);
    check("ks0_reads",   rd_cnt[0], 2);
    check("ks0_writes",  wr_cnt[0], 1);
    check("ks0_w0_addr", 32'(wa[0][0]), 32'h2);
    check("ks0_w0_data", 32'(wd[0][0]), 0);
    check("ks0_flag",    32'(fa[0]), 0);
    check("ks0_count",   32'(mc[0]), 0);

    // Oversized neighbour count, all neighbours in own cluster, stray start mid-scan
    mem[836] = 16'd2;
    mem[837] = 16'd200;
    for (int k = 0; k < 64; k++) mem[100 + k] = 16'd3;
    launch(0, 1'b1);
    wait_done(0, 1'b1, 400, 50, lat);
    check("clamp_done",    32'(done[0]), 1);
    check("clamp_latency", lat, 263);
    check("clamp_max_nbr", 32'(max_nbr[0]), 32'hC6);
    check("clamp_writes",  wr_cnt[0], 2);
    check("clamp_flag",    32'(fa[0]), 0);

    // Asynchronous reset while a sink entry is being read
    mem[837] = 16'd3;
    load_common();
    launch(0, 1'b1);
    repeat (12) @(negedge clock);
    check("ar_in_sink_rd", 32'(rd_en[0]), 1);
    check("ar_sink_addr",  32'(addr[0]), 32'h8);
    #1 nrst = 1'b0;
    #1;
    check("ar_busy",  32'(busy[0]),  0);
    check("ar_addr",  32'(addr[0]),  0);
    check("ar_rd_en", 32'(rd_en[0]), 0);
    check("ar_wr_en", 32'(wr_en[0]), 0);
    check("ar_done",  32'(done[0]),  0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    nrst = 1'b1;
    check("ar_no_write", wr_cnt[0], 0);
    launch(0, 1'b1);
    wait_done(0, 1'b1, 100, 0, lat);
    check("ar_re_done",    32'(done[0]), 1);
    check("ar_re_latency", lat, 27);
    check("ar_re_count",   32'(mc[0]), 1);
    check("ar_re_flag",    32'(fa[0]), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
